// File: rtl/insn_fetch_unit.sv
`timescale 1ns/1ps
// insn_fetch_unit
//   Instruction-fetch front end for the RV32I core. Holds the PC, fetches
//   words from instruction memory over a req/ack handshake and presents them
//   to decode over a valid/ready handshake. Taken jumps/branches redirect the
//   PC; a misaligned redirect target parks the unit in HALT until reset.
//
//   Optional build macro FETCH_BUF_EN adds a one-entry prefetch buffer so a
//   continuously accepting decoder sees one instruction per cycle. Without the
//   macro the unit alternates request/hold (one instruction per two cycles).
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   mem_req/mem_addr    fetch request and byte address (mem_addr == PC)
//   mem_ack/mem_rdata   memory response (ack ignored while mem_req=0)
//   INSN/insn_pc        instruction word and its address
//   insn_valid          INSN/insn_pc valid toward decode
//   insn_ready          decode accepts INSN
//   redirect/redirect_pc  load a new PC
//   misalign_err        sticky flag: redirect target not 4-byte aligned
module insn_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] INSN,
   output logic [31:0] insn_pc,
   output logic        insn_valid,
   input  logic        insn_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_HOLD = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   state_e      state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] insn_q,       insn_d;
   logic [31:0] insn_pc_q,    insn_pc_d;
   logic        insn_valid_q, insn_valid_d;
   logic        mem_req_q,    mem_req_d;
   logic        misalign_q,   misalign_d;
`ifdef FETCH_BUF_EN
   logic [31:0] buf_q,        buf_d;
   logic        buf_valid_q,  buf_valid_d;
`endif

   logic ack_ok;
   logic accept;

   // mem_req is a flop reset to 0: the reset state is REQ, but the request
   // only becomes visible once the first clock edge after reset release has
   // passed, and any ack seen before that is ignored.
   assign ack_ok = mem_ack && mem_req_q;
   assign accept = insn_valid_q && insn_ready;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      insn_d       = insn_q;
      insn_pc_d    = insn_pc_q;
      insn_valid_d = insn_valid_q;
      mem_req_d    = mem_req_q;
      misalign_d   = misalign_q;
`ifdef FETCH_BUF_EN
      buf_d        = buf_q;
      buf_valid_d  = buf_valid_q;
`endif

      if (state_q != ST_REQ && state_q != ST_HOLD) begin
         // HALT (and any unreachable encoding): parked until reset
         state_d      = ST_HALT;
         mem_req_d    = 1'b0;
         insn_valid_d = 1'b0;
         misalign_d   = 1'b1;
      end else if (redirect) begin
         // Redirect beats any same-cycle ack or accept
         insn_valid_d = 1'b0;
`ifdef FETCH_BUF_EN
         buf_valid_d  = 1'b0;
`endif
         if (redirect_pc[1:0] == 2'b00) begin
            pc_d      = redirect_pc;
            state_d   = ST_REQ;
            mem_req_d = 1'b1;
         end else begin
            state_d    = ST_HALT;
            mem_req_d  = 1'b0;
            misalign_d = 1'b1;
         end
      end else if (state_q == ST_REQ) begin
         mem_req_d = 1'b1;
         if (ack_ok) begin
            insn_d       = mem_rdata;
            insn_pc_d    = pc_q;
            insn_valid_d = 1'b1;
            state_d      = ST_HOLD;
`ifdef FETCH_BUF_EN
            // PC moves ahead to the prefetch address immediately
            pc_d         = pc_q + 32'd4;
            mem_req_d    = 1'b1;
`else
            mem_req_d    = 1'b0;
`endif
         end
      end else begin
         // HOLD
`ifdef FETCH_BUF_EN
         // Here pc_q is always insn_pc_q + 4, i.e. the prefetch/buffer address
         if (accept) begin
            if (buf_valid_q) begin
               insn_d      = buf_q;
               insn_pc_d   = pc_q;
               pc_d        = pc_q + 32'd4;
               buf_valid_d = 1'b0;
               mem_req_d   = 1'b1;
            end else if (ack_ok) begin
               // Prefetch lands in the same cycle as the accept: forward it
               insn_d      = mem_rdata;
               insn_pc_d   = pc_q;
               pc_d        = pc_q + 32'd4;
               mem_req_d   = 1'b1;
            end else begin
               // Nothing buffered: outstanding prefetch continues as REQ
               insn_valid_d = 1'b0;
               state_d      = ST_REQ;
               mem_req_d    = 1'b1;
            end
         end else if (ack_ok && !buf_valid_q) begin
            buf_d       = mem_rdata;
            buf_valid_d = 1'b1;
            mem_req_d   = 1'b0;
         end
`else
         mem_req_d = 1'b0;
         if (accept) begin
            insn_valid_d = 1'b0;
            pc_d         = insn_pc_q + 32'd4;
            state_d      = ST_REQ;
            mem_req_d    = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         insn_q       <= '0;
         insn_pc_q    <= RESET_PC;
         insn_valid_q <= 1'b0;
         mem_req_q    <= 1'b0;
         misalign_q   <= 1'b0;
`ifdef FETCH_BUF_EN
         buf_q        <= '0;
         buf_valid_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         insn_q       <= insn_d;
         insn_pc_q    <= insn_pc_d;
         insn_valid_q <= insn_valid_d;
         mem_req_q    <= mem_req_d;
         misalign_q   <= misalign_d;
`ifdef FETCH_BUF_EN
         buf_q        <= buf_d;
         buf_valid_q  <= buf_valid_d;
`endif
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_addr     = pc_q;
   assign INSN         = insn_q;
   assign insn_pc      = insn_pc_q;
   assign insn_valid   = insn_valid_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_insn_fetch_unit.sv
`timescale 1ns/1ps
// Bench for insn_fetch_unit (baseline build, RESET_PC = 0x100).
// A memory responder answers requests after a programmable wait; the
// stimulus queues each instruction it expects decode to receive, and a
// monitor pops/compares on every valid&ready handshake.
module tb_insn_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] INSN;
   logic [31:0] insn_pc;
   logic        insn_valid;
   logic        insn_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   insn_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .INSN(INSN), .insn_pc(insn_pc), .insn_valid(insn_valid),
      .insn_ready(insn_ready),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .misalign_err(misalign_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // memory responder controls
   logic        mem_en = 1'b1;
   int unsigned ack_delay = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] insn);
      exp_t e;
      e.pc   = pc;
      e.insn = insn;
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h0000_006F;
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory responder: ack after ack_delay waiting cycles at a stable address
   initial begin
      int unsigned cnt = 0;
      logic [31:0] last = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge CLK);
         #1;
         mem_ack = 1'b0;
         if (!mem_req || !mem_en) begin
            cnt = 0;
         end else begin
            if (mem_addr != last) cnt = 0;
            if (cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_word(mem_addr);
               cnt       = 0;
            end else begin
               mem_rdata = 32'hDEAD_BEEF;
               cnt++;
            end
         end
         last = mem_addr;
      end
   end

   // Monitor: every decode handshake must match the next queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (RST_N && insn_valid && insn_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_insn: got pc %h insn %h expected none", insn_pc, INSN);
            end else begin
               e = exp_q.pop_front();
               chk("mon_insn_pc", insn_pc, e.pc);
               chk("mon_INSN", INSN, e.insn);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      insn_ready  = 1'b1;
      push(32'h100, 32'hC0DE_0100);
      push(32'h104, 32'hC0DE_0104);
      push(32'h108, 32'hC0DE_0108);
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_valid", {31'd0, insn_valid}, 32'd0);
      chk("rst_INSN", INSN, 32'h0);
      chk("rst_insn_pc", insn_pc, 32'h100);
      chk("rst_mem_addr", mem_addr, 32'h100);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);

      // Zero-wait streaming: request every other cycle
      @(negedge CLK); RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("seq_mem_req", {31'd0, mem_req}, 32'd1);
         chk("seq_mem_addr", mem_addr, 32'h100 + 32'(k) * 32'd4);
         chk("seq_valid_lo", {31'd0, insn_valid}, 32'd0);
         @(negedge CLK);
         chk("seq_valid_hi", {31'd0, insn_valid}, 32'd1);
         chk("seq_insn_pc", insn_pc, 32'h100 + 32'(k) * 32'd4);
         chk("seq_hold_req", {31'd0, mem_req}, 32'd0);
      end

      // Decode stall for 5 cycles while holding 0x108
      insn_ready = 1'b0;
      mem_en     = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("stall_valid", {31'd0, insn_valid}, 32'd1);
         chk("stall_INSN", INSN, 32'hC0DE_0108);
         chk("stall_insn_pc", insn_pc, 32'h108);
         chk("stall_mem_req", {31'd0, mem_req}, 32'd0);
         chk("stall_mem_addr", mem_addr, 32'h108);
      end
      insn_ready = 1'b1;

      // Redirect to 0x200 while requesting 0x10C, then 3-cycle wait ack
      @(negedge CLK);
      chk("r0_mem_addr", mem_addr, 32'h10C);
      redirect = 1'b1; redirect_pc = 32'h200;
      @(negedge CLK);
      redirect = 1'b0; mem_en = 1'b1; ack_delay = 3;
      push(32'h200, 32'h0000_006F);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge CLK);
         chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
         chk("wait_mem_addr", mem_addr, 32'h200);
         chk("wait_valid", {31'd0, insn_valid}, 32'd0);
      end
      @(negedge CLK);
      chk("wait_done_valid", {31'd0, insn_valid}, 32'd1);
      chk("wait_done_INSN", INSN, 32'h0000_006F);
      ack_delay = 0;

      // Redirect in the same cycle as the ack of 0x204: data discarded
      @(negedge CLK);
      chk("r1_mem_addr", mem_addr, 32'h204);
      redirect = 1'b1; redirect_pc = 32'h400;
      @(negedge CLK);
      redirect = 1'b0;
      chk("r1_mem_req", {31'd0, mem_req}, 32'd1);
      chk("r1_new_addr", mem_addr, 32'h400);
      chk("r1_valid", {31'd0, insn_valid}, 32'd0);
      push(32'h400, 32'hC0DE_0400);
      @(negedge CLK);
      chk("r1_insn_pc", insn_pc, 32'h400);

      // PC wrap from 0xFFFFFFFC to 0
      @(negedge CLK);
      chk("r2_mem_addr", mem_addr, 32'h404);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      push(32'hFFFF_FFFC, 32'hC0DE_FFFC);
      push(32'h0000_0000, 32'hC0DE_0000);
      @(negedge CLK);
      redirect = 1'b0;
      chk("wrap_top_addr", mem_addr, 32'hFFFF_FFFC);
      chk("wrap_top_valid", {31'd0, insn_valid}, 32'd0);
      @(negedge CLK);
      chk("wrap_top_pc", insn_pc, 32'hFFFF_FFFC);
      @(negedge CLK);
      chk("wrap_req", {31'd0, mem_req}, 32'd1);
      chk("wrap_addr", mem_addr, 32'h0);
      chk("wrap_no_err", {31'd0, misalign_err}, 32'd0);
      @(negedge CLK);
      chk("wrap_insn_pc", insn_pc, 32'h0);
      mem_en = 1'b0;

      // Misaligned redirect -> HALT
      @(negedge CLK);
      chk("mis_pre_addr", mem_addr, 32'h4);
      redirect = 1'b1; redirect_pc = 32'h402;
      @(negedge CLK);
      redirect = 1'b0; mem_en = 1'b1;
      chk("halt_err", {31'd0, misalign_err}, 32'd1);
      chk("halt_req", {31'd0, mem_req}, 32'd0);
      chk("halt_valid", {31'd0, insn_valid}, 32'd0);
      chk("halt_pc", mem_addr, 32'h4);
      @(negedge CLK);
      redirect = 1'b1; redirect_pc = 32'h800;
      @(negedge CLK);
      redirect = 1'b0;
      chk("halt_ignore_redir_addr", mem_addr, 32'h4);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("halt_stay_req", {31'd0, mem_req}, 32'd0);
         chk("halt_stay_err", {31'd0, misalign_err}, 32'd1);
      end

      // Reset pulse recovers, fetch resumes at RESET_PC
      RST_N = 1'b0;
      #1;
      chk("rst2_err", {31'd0, misalign_err}, 32'd0);
      chk("rst2_req", {31'd0, mem_req}, 32'd0);
      chk("rst2_addr", mem_addr, 32'h100);
      push(32'h100, 32'hC0DE_0100);
      @(negedge CLK); RST_N = 1'b1;
      @(negedge CLK);
      chk("rst2_first_req", {31'd0, mem_req}, 32'd1);
      chk("rst2_first_addr", mem_addr, 32'h100);
      @(negedge CLK);
      chk("rst2_valid", {31'd0, insn_valid}, 32'd1);
      mem_en = 1'b0;

      for (int k = 0; k < 20; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge CLK);
      end
      @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
